// File: rtl/cmos_capture_pkg.sv
// Shared types and constants for the OV5640 DVP capture front-end:
// FSM states, channel-reorder modes and RGB565 field positions.
package cmos_capture_pkg;

    typedef enum logic [1:0] {
        WAIT_CFG = 2'd0,
        SKIP     = 2'd1,
        STREAM   = 2'd2
    } state_e;

    localparam logic [1:0] MODE_PASS     = 2'd0;
    localparam logic [1:0] MODE_RB       = 2'd1;
    localparam logic [1:0] MODE_BSWAP    = 2'd2;
    localparam logic [1:0] MODE_BSWAP_RB = 2'd3;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    function automatic logic [15:0] rb_swap(input logic [15:0] p);
        return {p[B_MSB:B_LSB], p[G_MSB:G_LSB], p[R_MSB:R_LSB]};
    endfunction

    // Mode 3 byte-swaps first so the R/B fields are located in the swapped word.
    function automatic logic [15:0] apply_mode(input logic [15:0] p, input logic [1:0] mode);
        logic [15:0] bswap;
        logic [15:0] res;
        bswap = {p[7:0], p[15:8]};
        case (mode)
            MODE_RB:       res = rb_swap(p);
            MODE_BSWAP:    res = bswap;
            MODE_BSWAP_RB: res = rb_swap(bswap);
            default:       res = p;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cmos_pixel_capture_if.sv
// Video output bus towards the frame buffer input port (vs_n/de/data).
interface cmos_pixel_capture_if #(
    parameter int PIX_W = 16
);
    logic             vs_n;
    logic             de;
    logic [PIX_W-1:0] data;

    modport master (output vs_n, de, data);
    modport slave  (input  vs_n, de, data);
endinterface

// File: rtl/cmos_byte_packer.sv
// Packs DVP bytes into pixels, applies the channel reorder and flags
// half pixels left pending at line end or lines cut by a frame start.
module cmos_byte_packer
    import cmos_capture_pkg::*;
#(
    parameter int BPP   = 2,
    parameter int PIX_W = 8 * BPP
) (
    input  logic             cmos_pclk,
    input  logic             I_rst_n,
    input  logic             href_i,
    input  logic [7:0]       data_i,
    input  logic             vs_rise_i,
    input  logic [1:0]       mode_i,
    output logic             pix_vld_o,
    output logic [PIX_W-1:0] pix_o,
    output logic             line_end_o,
    output logic             err_o
);

    logic             href_prev_q;
    logic             phase_q, phase_d;
    logic [7:0]       hi_q, hi_d;
    logic             drop_q, drop_d;
    logic             pix_vld_q, pix_vld_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             line_end_q, line_end_d;
    logic             err_q, err_d;
    logic             href_fall;

    assign href_fall = href_prev_q & ~href_i;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        phase_d    = phase_q;
        hi_d       = hi_q;
        drop_d     = drop_q;
        pix_vld_d  = 1'b0;
        pix_d      = pix_q;
        line_end_d = 1'b0;
        err_d      = 1'b0;

        if (vs_rise_i && href_i) begin
            // Line cut by a frame start: drop its bytes until href falls, never count it.
            err_d   = 1'b1;
            phase_d = 1'b0;
            drop_d  = 1'b1;
        end else if (href_fall) begin
            line_end_d = ~drop_q;
            drop_d     = 1'b0;
            err_d      = phase_q;
            phase_d    = 1'b0;
        end else if (href_i && !drop_q) begin
            if (BPP == 1) begin
                pix_vld_d = 1'b1;
                pix_d     = PIX_W'(data_i);
            end else if (!phase_q) begin
                hi_d    = data_i;
                phase_d = 1'b1;
            end else begin
                pix_vld_d = 1'b1;
                pix_d     = PIX_W'(apply_mode({hi_q, data_i}, mode_i));
                phase_d   = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            href_prev_q <= 1'b0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            drop_q      <= 1'b0;
            pix_vld_q   <= 1'b0;
            pix_q       <= '0;
            line_end_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            href_prev_q <= href_i;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            drop_q      <= drop_d;
            pix_vld_q   <= pix_vld_d;
            pix_q       <= pix_d;
            line_end_q  <= line_end_d;
            err_q       <= err_d;
        end
    end

    assign pix_vld_o  = pix_vld_q;
    assign pix_o      = pix_q;
    assign line_end_o = line_end_q;
    assign err_o      = err_q;

endmodule

// File: rtl/cmos_pixel_capture.sv
// OV5640 capture front-end: start-up frame skipping, decimation, crop window
// and vs_n/de/data generation for the frame buffer, all on the pixel clock.
module cmos_pixel_capture
    import cmos_capture_pkg::*;
#(
    parameter int BPP         = 2,
    parameter int CNT_W       = 12,
    parameter int SKIP_FRAMES = 4,
    parameter int DECIM_W     = 3,
    parameter int FCNT_W      = 16
) (
    input  logic               cmos_pclk,
    input  logic               I_rst_n,
    input  logic               I_cfg_done,
    input  logic               I_vsync,
    input  logic               I_href,
    input  logic [7:0]         I_data,
    input  logic [1:0]         I_mode,
    input  logic               I_crop_en,
    input  logic [CNT_W-1:0]   I_h_start,
    input  logic [CNT_W-1:0]   I_h_len,
    input  logic [CNT_W-1:0]   I_v_start,
    input  logic [CNT_W-1:0]   I_v_len,
    input  logic [DECIM_W-1:0] I_decim,
    cmos_pixel_capture_if.master vout,
    output logic [FCNT_W-1:0]  O_frame_cnt,
    output logic               O_line_err,
    output logic               O_active
);

    localparam int PIX_W  = 8 * BPP;
    localparam int SKIP_W = $clog2(SKIP_FRAMES + 2);

    logic             vsync_q, href_q, vs_d1_q, vs_d2_q;
    logic [7:0]       data_q;
    state_e           state_q, state_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic [DECIM_W-1:0] decim_cnt_q, decim_cnt_d;
    logic             keep_q, keep_d;
    logic             crop_en_q, crop_en_d;
    logic [CNT_W-1:0] h_start_q, h_start_d, h_len_q, h_len_d;
    logic [CNT_W-1:0] v_start_q, v_start_d, v_len_q, v_len_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic             line_err_q, line_err_d;
    logic             de_q, de_d, vs_n_q, vs_n_d;
    logic [PIX_W-1:0] pix_out_q, pix_out_d;

    logic             vs_rise, fs_stream, stream_now, keep_new, keep_eff, crop_ok;
    logic             pix_vld_w, line_end_w, err_w;
    logic [PIX_W-1:0] pix_w;
    logic [CNT_W:0]   h_end, v_end;

    // Packer sees the early rise; its registered outputs line up with vs_rise below.
    cmos_byte_packer #(.BPP(BPP), .PIX_W(PIX_W)) u_packer (
        .cmos_pclk  (cmos_pclk),
        .I_rst_n    (I_rst_n),
        .href_i     (href_q),
        .data_i     (data_q),
        .vs_rise_i  (vsync_q & ~vs_d1_q),
        .mode_i     (mode_q),
        .pix_vld_o  (pix_vld_w),
        .pix_o      (pix_w),
        .line_end_o (line_end_w),
        .err_o      (err_w)
    );

    assign vs_rise    = vs_d1_q & ~vs_d2_q;
    assign stream_now = I_cfg_done && (state_q == STREAM);

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        fs_stream  = 1'b0;
        if (!I_cfg_done) begin
            state_d    = WAIT_CFG;
            skip_cnt_d = '0;
        end else begin
            case (state_q)
                WAIT_CFG: begin
                    state_d    = SKIP;
                    skip_cnt_d = '0;
                end
                SKIP: begin
                    if (vs_rise) begin
                        if (skip_cnt_q == SKIP_W'(SKIP_FRAMES)) begin
                            state_d   = STREAM;
                            fs_stream = 1'b1;
                        end else begin
                            skip_cnt_d = skip_cnt_q + 1'b1;
                        end
                    end
                end
                STREAM:  fs_stream = vs_rise;
                default: state_d = WAIT_CFG;
            endcase
        end
    end

    assign h_end   = {1'b0, h_start_q} + {1'b0, h_len_q};
    assign v_end   = {1'b0, v_start_q} + {1'b0, v_len_q};
    assign crop_ok = !crop_en_q ||
                     ({1'b0, x_q} >= {1'b0, h_start_q} && {1'b0, x_q} < h_end &&
                      {1'b0, y_q} >= {1'b0, v_start_q} && {1'b0, y_q} < v_end);
    assign keep_new = (decim_cnt_q == '0);
    assign keep_eff = fs_stream ? keep_new : keep_q;

    always_comb begin
        decim_cnt_d = decim_cnt_q;
        keep_d      = keep_q;
        crop_en_d   = crop_en_q;
        h_start_d   = h_start_q;
        h_len_d     = h_len_q;
        v_start_d   = v_start_q;
        v_len_d     = v_len_q;
        mode_d      = mode_q;
        fcnt_d      = fcnt_q;
        line_err_d  = line_err_q;
        x_d         = x_q;
        y_d         = y_q;

        if (!I_cfg_done || state_q == WAIT_CFG) begin
            decim_cnt_d = '0;
            keep_d      = 1'b0;
        end else if (fs_stream) begin
            keep_d      = keep_new;
            decim_cnt_d = (decim_cnt_q == I_decim) ? '0 : decim_cnt_q + 1'b1;
            crop_en_d   = I_crop_en;
            h_start_d   = I_h_start;
            h_len_d     = I_h_len;
            v_start_d   = I_v_start;
            v_len_d     = I_v_len;
            mode_d      = I_mode;
            if (keep_new) begin
                fcnt_d     = fcnt_q + 1'b1;
                line_err_d = err_w;
            end
        end else if (err_w && stream_now && keep_q) begin
            line_err_d = 1'b1;
        end

        // x/y saturate instead of wrapping so oversized frames never re-enter the crop window.
        if (fs_stream) begin
            x_d = '0;
            y_d = '0;
        end else if (line_end_w) begin
            x_d = '0;
            if (y_q != '1) y_d = y_q + 1'b1;
        end else if (pix_vld_w && x_q != '1) begin
            x_d = x_q + 1'b1;
        end

        de_d      = pix_vld_w && keep_q && crop_ok && stream_now;
        pix_out_d = de_d ? pix_w : pix_out_q;
        vs_n_d    = !(vs_d1_q && keep_eff && I_cfg_done && (state_q == STREAM || fs_stream));
    end

    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= '0;
            vs_d1_q     <= 1'b0;
            vs_d2_q     <= 1'b0;
            state_q     <= WAIT_CFG;
            skip_cnt_q  <= '0;
            decim_cnt_q <= '0;
            keep_q      <= 1'b0;
            crop_en_q   <= 1'b0;
            h_start_q   <= '0;
            h_len_q     <= '0;
            v_start_q   <= '0;
            v_len_q     <= '0;
            mode_q      <= MODE_PASS;
            x_q         <= '0;
            y_q         <= '0;
            fcnt_q      <= '0;
            line_err_q  <= 1'b0;
            de_q        <= 1'b0;
            vs_n_q      <= 1'b1;
            pix_out_q   <= '0;
        end else begin
            vsync_q     <= I_vsync;
            href_q      <= I_href;
            data_q      <= I_data;
            vs_d1_q     <= vsync_q;
            vs_d2_q     <= vs_d1_q;
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            decim_cnt_q <= decim_cnt_d;
            keep_q      <= keep_d;
            crop_en_q   <= crop_en_d;
            h_start_q   <= h_start_d;
            h_len_q     <= h_len_d;
            v_start_q   <= v_start_d;
            v_len_q     <= v_len_d;
            mode_q      <= mode_d;
            x_q         <= x_d;
            y_q         <= y_d;
            fcnt_q      <= fcnt_d;
            line_err_q  <= line_err_d;
            de_q        <= de_d;
            vs_n_q      <= vs_n_d;
            pix_out_q   <= pix_out_d;
        end
    end

    assign vout.vs_n   = vs_n_q;
    assign vout.de     = de_q;
    assign vout.data   = pix_out_q;
    assign O_frame_cnt = fcnt_q;
    assign O_line_err  = line_err_q;
    assign O_active    = (state_q == STREAM);

endmodule

// File: tb/tb_cmos_pixel_capture.sv
// Directed bench for cmos_pixel_capture: skip, modes, crop, decimation,
// odd-byte lines and cfg_done loss, with hand-computed expectations.
module tb_cmos_pixel_capture;
    import cmos_capture_pkg::*;

    localparam int PIX_W = 16;
    localparam int CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst_n, cfg_done, vsync, href, crop_en;
    logic [7:0]       din;
    logic [1:0]       mode;
    logic [CNT_W-1:0] h_start, h_len, v_start, v_len;
    logic [2:0]       decim;
    logic [15:0]      frame_cnt;
    logic             line_err, active;

    cmos_pixel_capture_if #(.PIX_W(PIX_W)) vout ();

    cmos_pixel_capture #(
        .BPP(2), .CNT_W(CNT_W), .SKIP_FRAMES(2), .DECIM_W(3), .FCNT_W(16)
    ) dut (
        .cmos_pclk  (clk),
        .I_rst_n    (rst_n),
        .I_cfg_done (cfg_done),
        .I_vsync    (vsync),
        .I_href     (href),
        .I_data     (din),
        .I_mode     (mode),
        .I_crop_en  (crop_en),
        .I_h_start  (h_start),
        .I_h_len    (h_len),
        .I_v_start  (v_start),
        .I_v_len    (v_len),
        .I_decim    (decim),
        .vout       (vout),
        .O_frame_cnt(frame_cnt),
        .O_line_err (line_err),
        .O_active   (active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Output monitor, sampled 2 ns after each rising edge.
    int          de_cnt = 0;
    int          vs_falls = 0;
    logic        vs_n_prev = 1'b1;
    logic [15:0] de_log[$];

    always @(posedge clk) begin
        #2;
        if (vout.de) begin
            de_cnt++;
            de_log.push_back(vout.data);
        end
        if (vs_n_prev && !vout.vs_n) vs_falls++;
        vs_n_prev = vout.vs_n;
    end

    function automatic logic [15:0] log_at(input int i);
        return (i < de_log.size()) ? de_log[i] : 16'hDEAD;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        idle(3);
        vsync = 1'b0;
        idle(3);
    endtask

    // High byte carries the line number, low byte the pixel column.
    task automatic send_line(input int y, input int nbytes);
        for (int b = 0; b < nbytes; b++) begin
            href = 1'b1;
            din  = (b % 2 == 0) ? 8'(y) : 8'(b / 2);
            @(negedge clk);
        end
        href = 1'b0;
        din  = 8'h00;
        idle(4);
    endtask

    task automatic send_frame(input int w, input int h);
        frame_start();
        for (int y = 0; y < h; y++) send_line(y, 2 * w);
        idle(4);
    endtask

    logic [15:0] mode_exp [4] = '{16'hF81F, 16'hF81F, 16'h1FF8, 16'hC7E3};
    int exp_fcnt;

    initial begin
        rst_n = 1'b0; cfg_done = 1'b0; vsync = 1'b0; href = 1'b0; din = 8'h00;
        mode = MODE_PASS; crop_en = 1'b0; decim = 3'd0;
        h_start = '0; h_len = '0; v_start = '0; v_len = '0;
        idle(3);
        check("rst_vs_n", vout.vs_n, 1);
        check("rst_de", vout.de, 0);
        check("rst_data", vout.data, 0);
        check("rst_fcnt", frame_cnt, 0);
        check("rst_err", line_err, 0);
        check("rst_active", active, 0);
        rst_n = 1'b1;
        idle(2);

        // Two skipped frames, then two streamed 8x4 frames.
        cfg_done = 1'b1;
        idle(4);
        vs_falls = 0;
        for (int f = 1; f <= 4; f++) begin
            de_cnt = 0;
            send_frame(8, 4);
            check($sformatf("skip_f%0d_de", f), de_cnt, (f <= 2) ? 0 : 32);
        end
        exp_fcnt = 2;
        check("skip_fcnt", frame_cnt, exp_fcnt);
        check("skip_active", active, 1);
        check("skip_last_data", vout.data, 16'h0307);
        check("skip_vs_pulses", vs_falls, 2);
        check("skip_vs_idle", vout.vs_n, 1);

        // One F8/1F pixel per frame in each mode; O_de exactly 2 pclk after the low byte edge.
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            frame_start();
            href = 1'b1; din = 8'hF8;
            @(negedge clk);
            din = 8'h1F;
            @(negedge clk);
            href = 1'b0; din = 8'h00;
            check($sformatf("mode%0d_de_p0", m), vout.de, 0);
            @(negedge clk);
            check($sformatf("mode%0d_de_p1", m), vout.de, 0);
            @(negedge clk);
            check($sformatf("mode%0d_de_p2", m), vout.de, 1);
            check($sformatf("mode%0d_data", m), vout.data, mode_exp[m]);
            idle(6);
        end
        exp_fcnt += 4;
        check("mode_fcnt", frame_cnt, exp_fcnt);
        mode = MODE_PASS;

        // Crop window columns 2..4, lines 1..2.
        crop_en = 1'b1; h_start = 12'd2; h_len = 12'd3; v_start = 12'd1; v_len = 12'd2;
        de_cnt = 0;
        de_log.delete();
        send_frame(8, 4);
        check("crop_de", de_cnt, 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("crop_px%0d", i), log_at(i), {8'(1 + i / 3), 8'(2 + i % 3)});
        crop_en = 1'b0;
        exp_fcnt += 1;

        // Keep 1 of 3 frames over six frames.
        decim = 3'd2;
        de_cnt = 0;
        vs_falls = 0;
        repeat (6) send_frame(2, 1);
        check("decim_de", de_cnt, 4);
        check("decim_vs_pulses", vs_falls, 2);
        exp_fcnt += 2;
        check("decim_fcnt", frame_cnt, exp_fcnt);
        decim = 3'd0;

        // Seven-byte line: three pixels, trailing byte dropped, sticky error.
        de_cnt = 0;
        de_log.delete();
        frame_start();
        send_line(0, 7);
        idle(4);
        check("odd_de", de_cnt, 3);
        check("odd_last_px", log_at(2), 16'h0002);
        check("odd_err_set", line_err, 1);
        frame_start();
        check("odd_err_clear", line_err, 0);
        send_line(0, 4);
        exp_fcnt += 2;
        check("odd_fcnt", frame_cnt, exp_fcnt);

        // cfg_done lost mid-line, then restored: skip frames apply again.
        frame_start();
        exp_fcnt += 1;
        de_cnt = 0;
        for (int b = 0; b < 16; b++) begin
            href = 1'b1;
            din  = (b % 2 == 0) ? 8'h00 : 8'(b / 2);
            if (b == 8) cfg_done = 1'b0;
            @(negedge clk);
            if (b == 8) begin
                check("drop_de_next", vout.de, 0);
                check("drop_active", active, 0);
            end
        end
        href = 1'b0; din = 8'h00;
        idle(6);
        check("drop_de_total", de_cnt, 3);
        check("drop_vs_n", vout.vs_n, 1);
        cfg_done = 1'b1;
        idle(4);
        for (int f = 1; f <= 3; f++) begin
            de_cnt = 0;
            send_frame(2, 1);
            check($sformatf("reskip_f%0d_de", f), de_cnt, (f <= 2) ? 0 : 2);
        end
        exp_fcnt += 1;
        check("reskip_fcnt", frame_cnt, exp_fcnt);
        check("reskip_active", active, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
